// File: rtl/if_fetch_stage_if.sv
// Instruction-memory port between the fetch stage (master) and the instruction ROM (slave).
// rom_req/rom_addr form the request, rom_ack accepts it, and rom_rvalid/rom_rdata return the data.
interface if_fetch_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32
);
  logic                  rom_req;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic                  rom_ack;
  logic                  rom_rvalid;
  logic [INST_WIDTH-1:0] rom_rdata;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_ack,
    input  rom_rvalid,
    input  rom_rdata
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_ack,
    output rom_rvalid,
    output rom_rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one ROM request outstanding, and uses a one-entry skid buffer.
// Define FETCH_ADDR_EXC_EN to add addr_exc_out. A misaligned PC then becomes an exception slot instead of a fetch.
module if_fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_next_stage,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  if_fetch_stage_if.master      rom,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic                  valid_out
`ifdef FETCH_ADDR_EXC_EN
  ,
  output logic                  addr_exc_out
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] req_pc_r;
  logic [INST_WIDTH-1:0] skid_r;
  logic                  kill_r;
`ifdef FETCH_ADDR_EXC_EN
  logic                  exc_done_r;
`endif

  logic consume_s;
  logic slot_free_s;
  logic pc_misaligned_s;
  logic rom_req_s;

  // Output-slot handshake and request decode from state and PC.
  always_comb begin
    consume_s       = valid_out && !stall_next_stage;
    slot_free_s     = !valid_out || consume_s;
    pc_misaligned_s = 1'b0;
`ifdef FETCH_ADDR_EXC_EN
    pc_misaligned_s = (pc_r[1:0] != 2'b00);
`endif
    rom_req_s       = (state_r == S_REQ) && !rst && !pc_misaligned_s;
  end

  assign rom.rom_req  = rom_req_s;
  assign rom.rom_addr = pc_r;

  // Fetch FSM, PC, skid buffer and the registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_REQ;
      pc_r      <= RESET_PC;
      req_pc_r  <= '0;
      skid_r    <= '0;
      kill_r    <= 1'b0;
      valid_out <= 1'b0;
      addr_out  <= '0;
      inst_out  <= '0;
`ifdef FETCH_ADDR_EXC_EN
      addr_exc_out <= 1'b0;
      exc_done_r   <= 1'b0;
`endif
    end else if (redirect) begin
      valid_out <= 1'b0;
      pc_r      <= redirect_pc;
`ifdef FETCH_ADDR_EXC_EN
      addr_exc_out <= 1'b0;
      exc_done_r   <= 1'b0;
`endif
      case (state_r)
        S_REQ: begin
          if (rom_req_s && rom.rom_ack) begin
            state_r <= S_WAIT;
            kill_r  <= 1'b1;
          end else begin
            state_r <= S_REQ;
          end
        end
        // Stay in WAIT until the stale response drains so that kill pairs with that response.
        S_WAIT: begin
          if (rom.rom_rvalid) begin
            state_r <= S_REQ;
            kill_r  <= 1'b0;
          end else begin
            kill_r  <= 1'b1;
          end
        end
        S_HOLD:  state_r <= S_REQ;
        default: state_r <= S_REQ;
      endcase
    end else begin
      if (consume_s) begin
        valid_out <= 1'b0;
      end
      case (state_r)
        S_REQ: begin
          if (rom_req_s && rom.rom_ack) begin
            req_pc_r <= pc_r;
            state_r  <= S_WAIT;
          end
`ifdef FETCH_ADDR_EXC_EN
          else if (pc_misaligned_s && !exc_done_r && slot_free_s) begin
            addr_out     <= pc_r;
            inst_out     <= '0;
            valid_out    <= 1'b1;
            addr_exc_out <= 1'b1;
            exc_done_r   <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          if (rom.rom_rvalid) begin
            if (kill_r) begin
              kill_r  <= 1'b0;
              state_r <= S_REQ;
            end else if (slot_free_s) begin
              addr_out  <= req_pc_r;
              inst_out  <= rom.rom_rdata;
              valid_out <= 1'b1;
`ifdef FETCH_ADDR_EXC_EN
              addr_exc_out <= 1'b0;
`endif
              pc_r      <= req_pc_r + PC_STEP;
              state_r   <= S_REQ;
            end else begin
              skid_r  <= rom.rom_rdata;
              pc_r    <= req_pc_r + PC_STEP;
              state_r <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free_s) begin
            addr_out  <= req_pc_r;
            inst_out  <= skid_r;
            valid_out <= 1'b1;
`ifdef FETCH_ADDR_EXC_EN
            addr_exc_out <= 1'b0;
`endif
            state_r   <= S_REQ;
          end
        end
        default: state_r <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios and then random stall/redirect/reset traffic.
// A scoreboard compares the consumed instruction stream with a program-order model.
module tb_if_fetch_stage;
  localparam int          AW       = 32;
  localparam int          IW       = 32;
  localparam logic [31:0] RESET_PC = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_next_stage = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] addr_out;
  logic [31:0] inst_out;
  logic        valid_out;
`ifdef FETCH_ADDR_EXC_EN
  logic        addr_exc_out;
`endif

  if_fetch_stage_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) rom_bus ();

  if_fetch_stage #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .stall_next_stage(stall_next_stage),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .rom(rom_bus),
    .addr_out(addr_out),
    .inst_out(inst_out),
    .valid_out(valid_out)
`ifdef FETCH_ADDR_EXC_EN
    ,
    .addr_exc_out(addr_exc_out)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cycle);
  endtask

  // The ROM contents are a fixed scramble of the address.
  function automatic logic [31:0] ref_inst(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  // ROM model: one outstanding request, random accept, and response latency mem_dly_min..mem_dly_max.
  int          mem_ack_pct = 100;
  int          mem_dly_min = 1;
  int          mem_dly_max = 1;
  bit          force_next = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] acc_q[$];

  initial begin
    rom_bus.rom_ack    = 1'b0;
    rom_bus.rom_rvalid = 1'b0;
    rom_bus.rom_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      rom_bus.rom_rvalid = 1'b0;
      rom_bus.rom_rdata  = $urandom;
      if (mem_cnt > 0) begin
        mem_cnt = mem_cnt - 1;
        if (mem_cnt == 0) begin
          rom_bus.rom_rvalid = 1'b1;
          rom_bus.rom_rdata  = mem_data;
        end
      end
      rom_bus.rom_ack = 1'b0;
      if (mem_cnt == 0 && rom_bus.rom_req && ($urandom_range(99) < mem_ack_pct)) begin
        rom_bus.rom_ack = 1'b1;
        acc_q.push_back(rom_bus.rom_addr);
        mem_data   = force_next ? 32'hDEADBEEF : ref_inst(rom_bus.rom_addr);
        force_next = 1'b0;
        mem_cnt    = $urandom_range(mem_dly_max, mem_dly_min);
      end
    end
  end

  // Scoreboard: exp_q holds the program-order addresses that ID should consume next.
  logic [31:0] exp_q[$];
  int          consumed = 0;
  int          cons_cyc[$];
  bit          saw_dead = 1'b0;

  initial begin
    logic [31:0] e;
    logic [31:0] hold_a;
    logic [31:0] hold_i;
    bit          hold_chk;
    hold_chk = 1'b0;
    hold_a   = 32'h0;
    hold_i   = 32'h0;
    forever begin
      @(negedge clk);
      if (valid_out && inst_out == 32'hDEADBEEF) saw_dead = 1'b1;
      if (hold_chk) begin
        check("stall_valid_frozen", {31'd0, valid_out}, 32'd1);
        check("stall_addr_frozen", addr_out, hold_a);
        check("stall_inst_frozen", inst_out, hold_i);
        hold_chk = 1'b0;
      end
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(RESET_PC);
      end else begin
        if (valid_out && !stall_next_stage) begin
          e = exp_q.pop_front();
          check("stream_addr", addr_out, e);
          check("stream_inst", inst_out, ref_inst(e));
          consumed++;
          cons_cyc.push_back(cycle);
          if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
        end else if (valid_out && stall_next_stage && !redirect) begin
          hold_chk = 1'b1;
          hold_a   = addr_out;
          hold_i   = inst_out;
        end
        if (redirect) begin
          exp_q.delete();
          exp_q.push_back(redirect_pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_next_stage = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    check("rst_rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_addr", addr_out, 32'd0);
    check("rst_inst", inst_out, 32'd0);
    acc_q.delete();
    cons_cyc.delete();
    rst = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    int k = 0;
    while (acc_q.size() < n && k < 200) begin
      tick();
      k++;
    end
    if (acc_q.size() < n) timeout_fail(name);
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!valid_out && k < 200) begin
      tick();
      k++;
    end
    if (!valid_out) timeout_fail(name);
  endtask

  task automatic wait_cons(input int n, input string name);
    int k = 0;
    while (cons_cyc.size() < n && k < 200) begin
      tick();
      k++;
    end
    if (cons_cyc.size() < n) timeout_fail(name);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int start_cons;

    // Sequential fetch with an always-ready ROM.
    mem_ack_pct = 100; mem_dly_min = 1; mem_dly_max = 1;
    do_reset();
    wait_cons(3, "t1_consumes");
    if (acc_q.size() >= 3) begin
      check("t1_rom_addr0", acc_q[0], 32'hBFC00000);
      check("t1_rom_addr1", acc_q[1], 32'hBFC00004);
      check("t1_rom_addr2", acc_q[2], 32'hBFC00008);
    end else begin
      timeout_fail("t1_rom_addrs");
    end
    if (cons_cyc.size() >= 3) begin
      check("t1_gap01_le3", (cons_cyc[1] - cons_cyc[0] <= 3) ? 32'd1 : 32'd0, 32'd1);
      check("t1_gap12_le3", (cons_cyc[2] - cons_cyc[1] <= 3) ? 32'd1 : 32'd0, 32'd1);
    end

    // Five stalled cycles push the second response into the skid.
    do_reset();
    wait_valid("t2_first_valid");
    stall_next_stage = 1'b1;
    repeat (5) tick();
    check("t2_hold_no_req", {31'd0, rom_bus.rom_req}, 32'd0);
    check("t2_hold_addr", addr_out, 32'hBFC00000);
    check("t2_hold_valid", {31'd0, valid_out}, 32'd1);
    stall_next_stage = 1'b0;
    tick();
    check("t2_skid_valid", {31'd0, valid_out}, 32'd1);
    check("t2_skid_addr", addr_out, 32'hBFC00004);
    check("t2_req_count", acc_q.size(), 32'd2);

    // Redirect during WAIT; the stale DEADBEEF response arrives two cycles later.
    mem_dly_min = 3; mem_dly_max = 3;
    force_next = 1'b1;
    do_reset();
    wait_acc(1, "t3_first_ack");
    redirect = 1'b1;
    redirect_pc = 32'h80001000;
    tick();
    redirect = 1'b0;
    wait_acc(2, "t3_second_ack");
    if (acc_q.size() >= 2) check("t3_next_rom_addr", acc_q[1], 32'h80001000);
    wait_valid("t3_target_valid");
    check("t3_target_addr", addr_out, 32'h80001000);

    // Redirect in the same cycle as rom_ack and a consume.
    mem_dly_min = 1; mem_dly_max = 1;
    do_reset();
    wait_valid("t4_first_valid");
    redirect = 1'b1;
    redirect_pc = 32'h80002000;
    tick();
    redirect = 1'b0;
    check("t4_valid_cleared", {31'd0, valid_out}, 32'd0);
    wait_valid("t4_target_valid");
    check("t4_target_addr", addr_out, 32'h80002000);

    // Reset while in WAIT with rom_rvalid high in the same cycle.
    mem_dly_min = 2; mem_dly_max = 2;
    do_reset();
    wait_acc(3, "t5_third_ack");
    tick();
    rst = 1'b1;
    #1;
    check("t5_req_in_rst", {31'd0, rom_bus.rom_req}, 32'd0);
    tick();
    rst = 1'b0;
    check("t5_valid_zero", {31'd0, valid_out}, 32'd0);
    check("t5_addr_zero", addr_out, 32'd0);
    check("t5_inst_zero", inst_out, 32'd0);
    wait_acc(4, "t5_restart_ack");
    if (acc_q.size() >= 4) check("t5_restart_addr", acc_q[3], RESET_PC);

`ifdef FETCH_ADDR_EXC_EN
    // A misaligned redirect target becomes an exception slot, and no request is made.
    mem_dly_min = 1; mem_dly_max = 1;
    do_reset();
    wait_valid("t6_first_valid");
    stall_next_stage = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h80000002;
    tick();
    redirect = 1'b0;
    start_cons = acc_q.size();
    repeat (6) begin
      tick();
      check("t6_no_rom_req", {31'd0, rom_bus.rom_req}, 32'd0);
    end
    check("t6_no_new_ack", acc_q.size(), start_cons);
    check("t6_exc_valid", {31'd0, valid_out}, 32'd1);
    check("t6_exc_addr", addr_out, 32'h80000002);
    check("t6_exc_inst", inst_out, 32'd0);
    check("t6_exc_flag", {31'd0, addr_exc_out}, 32'd1);
    stall_next_stage = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h80003000;
    tick();
    redirect = 1'b0;
    check("t6_exc_cleared", {31'd0, addr_exc_out}, 32'd0);
    wait_valid("t6_after_exc_valid");
    check("t6_after_exc_addr", addr_out, 32'h80003000);
`endif

    // Random traffic with stalls, redirects and occasional resets.
    mem_ack_pct = 70; mem_dly_min = 1; mem_dly_max = 4;
    do_reset();
    start_cons = consumed;
    for (int i = 0; i < 3000; i++) begin
      stall_next_stage = ($urandom_range(99) < 30);
      redirect = ($urandom_range(99) < 3);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      rst = ($urandom_range(999) < 3);
      tick();
    end
    stall_next_stage = 1'b0;
    redirect = 1'b0;
    rst = 1'b0;
    repeat (20) tick();
    check("rand_progress", (consumed - start_cons > 100) ? 32'd1 : 32'd0, 32'd1);
    check("deadbeef_never_presented", {31'd0, saw_dead}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
